// File: rtl/trng_ctrl_pkg.sv
// Shared types and constants for the TRNG sequencer.
package trng_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WARMUP, SAMPLE, HOLD, FAIL} state_e;

  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int LANES      = 4;
  localparam int APT_WINDOW = 64;
  localparam int APT_CUTOFF = 40;
endpackage

// File: rtl/trng_ctrl_fifo.sv
// Word FIFO with flush and a combinational head (zero when empty).
module trng_ctrl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: warm-up, divided sampling, health tests, 4-byte packing, FIFO.
// Define TRNG_CTRL_APT_EN to add the adaptive proportion test.
module trng_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [BYTE_W-1:0] trng_r,
  output logic              trng_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              health_fail,
  output logic              busy
);
  localparam int WCW = $clog2(WARMUP_CYCLES) + 1;
  localparam int DVW = $clog2(SAMPLE_DIV);
  localparam int RPW = $clog2(REP_LIMIT + 1);
  localparam int LNW = $clog2(LANES);

  state_e            state_q;
  logic              trng_en_q, hf_q, pend_q;
  logic [WCW-1:0]    warm_q;
  logic [DVW-1:0]    div_q;
  logic [LNW-1:0]    lane_q;
  logic [WORD_W-1:0] pack_q;
  logic [BYTE_W-1:0] prev_q;
  logic [RPW-1:0]    rep_q, rep_d;
  logic              cap, trip, rep_trip, apt_trip;
  logic              pop, push_ok, full, empty, flush;

  assign cap      = (state_q == SAMPLE) && (div_q == '0);
  // rep_q == 0 marks "no previous capture" since the last clear.
  assign rep_d    = (rep_q != '0 && trng_r == prev_q) ? rep_q + RPW'(1) : RPW'(1);
  assign rep_trip = (rep_d == RPW'(REP_LIMIT));

`ifdef TRNG_CTRL_APT_EN
  logic [$clog2(APT_WINDOW)-1:0] apt_idx_q;
  logic [BYTE_W-1:0]             apt_ref_q;
  logic [6:0]                    apt_cnt_q, apt_cnt_d;

  assign apt_cnt_d = (apt_idx_q == '0) ? 7'd1 : apt_cnt_q + 7'(trng_r == apt_ref_q);
  assign apt_trip  = (apt_cnt_d > 7'(APT_CUTOFF));
`else
  assign apt_trip  = 1'b0;
`endif

  assign trip    = cap && (rep_trip || apt_trip);
  assign pop     = rd_valid && rd_ready;
  assign push_ok = pend_q && (!full || pop);
  assign flush   = !run || (state_q == FAIL) || trip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !run) begin
      state_q   <= IDLE;
      trng_en_q <= 1'b0;
      hf_q      <= 1'b0;
      pend_q    <= 1'b0;
      warm_q    <= '0;
      div_q     <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      prev_q    <= '0;
      rep_q     <= '0;
`ifdef TRNG_CTRL_APT_EN
      apt_idx_q <= '0;
      apt_ref_q <= '0;
      apt_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= WARMUP;
          trng_en_q <= 1'b1;
          warm_q    <= '0;
        end
        WARMUP: begin
          if (warm_q == WCW'(WARMUP_CYCLES - 1)) begin
            state_q <= SAMPLE;
            div_q   <= DVW'(SAMPLE_DIV - 1);
          end else begin
            warm_q <= warm_q + WCW'(1);
          end
        end
        SAMPLE: begin
          // A pending word only exists for the one cycle after the 4th capture.
          if (pend_q) begin
            if (push_ok) pend_q  <= 1'b0;
            else         state_q <= HOLD;
          end
          if (cap) begin
            div_q                              <= DVW'(SAMPLE_DIV - 1);
            pack_q[int'(lane_q)*BYTE_W +: BYTE_W] <= trng_r;
            lane_q                             <= lane_q + LNW'(1);
            prev_q                             <= trng_r;
            rep_q                              <= rep_d;
            if (lane_q == LNW'(LANES - 1)) pend_q <= 1'b1;
`ifdef TRNG_CTRL_APT_EN
            apt_idx_q <= apt_idx_q + 1'b1;
            apt_cnt_d_store: begin
              apt_cnt_q <= apt_cnt_d;
              if (apt_idx_q == '0) apt_ref_q <= trng_r;
            end
`endif
            if (trip) begin
              state_q   <= FAIL;
              trng_en_q <= 1'b0;
              hf_q      <= 1'b1;
              pend_q    <= 1'b0;
              lane_q    <= '0;
              pack_q    <= '0;
            end
          end else begin
            div_q <= div_q - DVW'(1);
          end
        end
        HOLD: begin
          if (push_ok) begin
            pend_q  <= 1'b0;
            state_q <= SAMPLE;
            div_q   <= DVW'(SAMPLE_DIV - 1);
          end
        end
        FAIL: begin
          trng_en_q <= 1'b0;
          hf_q      <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  trng_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok && (state_q == SAMPLE || state_q == HOLD)),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (pack_q),
    .dout_o  (rd_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rd_valid    = !empty;
  assign trng_en     = trng_en_q;
  assign health_fail = hf_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: vector table, timed corner sequences, randomized model run.
module tb_trng_ctrl;
  logic        clk = 1'b0;
  logic        rst, run, rd_ready;
  logic [7:0]  trng_r;
  logic        trng_en, rd_valid, health_fail, busy;
  logic [31:0] rd_data;
  int          checks = 0;
  int          errors = 0;

  trng_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .trng_r      (trng_r),
    .trng_en     (trng_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .health_fail (health_fail),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    int          n;
    logic        en, bsy, vld, hf;
    logic [31:0] data;
  } vec_t;

  vec_t        tbl [10];
  int          mt;
  logic [31:0] mq [$];
  logic [7:0]  mb [$];
  logic        mpend;
  logic [31:0] mpw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; rd_ready = 1'b0; trng_r = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Word n of the stepping sequence: capture c sees byte (c*8 + 280) mod 256.
  function automatic logic [31:0] stepw(input int n);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(280 + 8 * (4 * n + k));
    return w;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk("reset_en", {31'b0, trng_en}, 32'd0);
    chk("reset_vld", {31'b0, rd_valid}, 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_hf", {31'b0, health_fail}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);

    // ---------------- capture timing, packing, HOLD, reset mid-run ----------------
    run = 1'b1; rd_ready = 1'b0;
    for (int t = 0; t <= 500; t++) begin
      trng_r   = 8'(t + 16);
      rd_ready = (t >= 431 && t <= 435);
      tick();
      if (t == 0)   chk("start_en", {31'b0, trng_en}, 32'd1);
      if (t == 0)   chk("start_busy", {31'b0, busy}, 32'd1);
      if (t == 288) chk("pre_word_vld", {31'b0, rd_valid}, 32'd0);
      if (t == 289) chk("first_word_vld", {31'b0, rd_valid}, 32'd1);
      if (t == 289) chk("first_word", rd_data, stepw(0));
      if (t == 420) chk("hold_en", {31'b0, trng_en}, 32'd1);
      if (t == 420) chk("hold_head", rd_data, stepw(0));
      if (t == 431) chk("pop_push_vld", {31'b0, rd_valid}, 32'd1);
      if (t == 431) chk("pop_push_head", rd_data, stepw(1));
      if (t == 434) chk("fifth_word", rd_data, stepw(4));
      if (t == 435) chk("drained_vld", {31'b0, rd_valid}, 32'd0);
      if (t == 463) chk("post_hold_vld", {31'b0, rd_valid}, 32'd0);
      if (t == 464) chk("post_hold_word", rd_data, 32'hDFD7CFC7);
    end
    #3 rst = 1'b1;
    #1;
    chk("async_rst_en", {31'b0, trng_en}, 32'd0);
    chk("async_rst_vld", {31'b0, rd_valid}, 32'd0);
    chk("async_rst_data", rd_data, 32'd0);
    chk("async_rst_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i % 25 == 24) chk("no_stale_word", {31'b0, rd_valid}, 32'd0);
    end

    // ---------------- vector table: repetition trip, FAIL, recovery ----------------
    tbl[0] = '{1'b0,   2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1,   1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 289, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[3] = '{1'b1,  94, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[4] = '{1'b1,   1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[5] = '{1'b1,   5, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[6] = '{1'b0,   1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b1,   1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 288, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hA5A5A5A5};
    do_reset();
    trng_r = 8'hA5; rd_ready = 1'b0;
    for (int r = 0; r < 10; r++) begin
      run = tbl[r].run;
      for (int i = 0; i < tbl[r].n; i++) tick();
      chk($sformatf("vec%0d_en", r), {31'b0, trng_en}, {31'b0, tbl[r].en});
      chk($sformatf("vec%0d_busy", r), {31'b0, busy}, {31'b0, tbl[r].bsy});
      chk($sformatf("vec%0d_vld", r), {31'b0, rd_valid}, {31'b0, tbl[r].vld});
      chk($sformatf("vec%0d_hf", r), {31'b0, health_fail}, {31'b0, tbl[r].hf});
      chk($sformatf("vec%0d_data", r), rd_data, tbl[r].data);
    end

    // ---------------- randomized run against a queue model ----------------
    do_reset();
    mt = -1; mq.delete(); mb.delete(); mpend = 1'b0; mpw = '0;
    for (int cyc = 0; cyc < 1400; cyc++) begin
      logic popped;
      run      = (cyc != 700);
      trng_r   = 8'($urandom);
      rd_ready = (mq.size() >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!run) begin
        mt = -1; mq.delete(); mb.delete(); mpend = 1'b0;
      end else if (mt < 0) begin
        mt = 0;
      end else begin
        mt++;
        popped = (mq.size() > 0) && rd_ready;
        if (mpend) begin mq.push_back(mpw); mpend = 1'b0; end
        if (popped) void'(mq.pop_front());
        if (mt >= 264 && (mt - 264) % 8 == 0) begin
          mb.push_back(trng_r);
          if (mb.size() == 4) begin
            mpw   = {mb[3], mb[2], mb[1], mb[0]};
            mpend = 1'b1;
            mb.delete();
          end
        end
      end
      tick();
      chk("rnd_en", {31'b0, trng_en}, {31'b0, mt >= 0});
      chk("rnd_vld", {31'b0, rd_valid}, {31'b0, mq.size() > 0});
      chk("rnd_data", rd_data, (mq.size() > 0) ? mq[0] : 32'h0);
      if (cyc % 100 == 0) chk("rnd_hf", {31'b0, health_fail}, 32'd0);
    end

    // ---------------- adaptive proportion pattern ----------------
    do_reset();
    run = 1'b1; rd_ready = 1'b1;
    for (int t = 0; t <= 790; t++) begin
      int c;
      c = (t >= 257) ? (t - 257) / 8 : 0;
      trng_r = (c % 4 == 3) ? 8'(8'h40 + c) : 8'h3C;
      tick();
    end
`ifdef TRNG_CTRL_APT_EN
    chk("apt_hf", {31'b0, health_fail}, 32'd1);
    chk("apt_en", {31'b0, trng_en}, 32'd0);
    chk("apt_vld", {31'b0, rd_valid}, 32'd0);
`else
    chk("apt_hf", {31'b0, health_fail}, 32'd0);
    chk("apt_en", {31'b0, trng_en}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
